pci_bus_arbiter: RTL and testbench

- Central PCI arbiter, the other end of each device controller's req/gnt handshake.
- Takes active-low requests from up to NUM_MASTERS bus devices and grants the bus to one at a time, round-robin.
- Tracks bus ownership by sampling the shared frame/irdy lines and parks the bus on a default master when no one requests.
- Revokes grants a master never uses.

---
 rtl/pci_bus_arbiter_if.sv | 25 ++
 rtl/pci_bus_arbiter.sv | 149 ++++++++++++++
 tb/tb_pci_bus_arbiter.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/pci_bus_arbiter_if.sv
// Shared PCI arbitration signals between the central arbiter and the bus devices.
// The master modport is the arbiter's view; slave is the device-side view.
interface pci_bus_arbiter_if #(
  parameter int unsigned NUM_MASTERS = 4
);
  localparam int unsigned OWNER_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  logic [NUM_MASTERS-1:0] req_n;
  logic                   frame_n;
  logic                   irdy_n;
  logic [NUM_MASTERS-1:0] gnt_n;
  logic [OWNER_W-1:0]     owner;
  logic                   bus_busy;
  logic                   timeout_pulse;

  modport master (
    input  req_n, frame_n, irdy_n,
    output gnt_n, owner, bus_busy, timeout_pulse
  );

  modport slave (
    output req_n, frame_n, irdy_n,
    input  gnt_n, owner, bus_busy, timeout_pulse
  );
endinterface

// File: rtl/pci_bus_arbiter.sv
// Round-robin central PCI arbiter: one grant at a time, parks on a default master,
// always passes through an all-deasserted cycle between owners, revokes unused grants.
module pci_bus_arbiter #(
  parameter int unsigned NUM_MASTERS = 4,
  parameter int unsigned GNT_TIMEOUT = 16,
  parameter int unsigned PARK_MASTER = 0
) (
  input logic              clk,
  input logic              reset,
  pci_bus_arbiter_if.master bus
);
  localparam int unsigned IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int unsigned TMR_W = $clog2(GNT_TIMEOUT + 1);
  localparam logic [IDX_W-1:0] PARK_IDX = IDX_W'(PARK_MASTER);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(GNT_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] TMR_MAX  = TMR_W'(GNT_TIMEOUT);

  typedef enum logic [1:0] {SWITCH, PARK, GRANTED, BUSY} state_t;

  state_t                 state_q, state_d;
  logic [NUM_MASTERS-1:0] gnt_q, gnt_d;
  logic [IDX_W-1:0]       owner_q, owner_d;
  logic [IDX_W-1:0]       ptr_q, ptr_d;
  logic [IDX_W-1:0]       target_q, target_d;
  logic [TMR_W-1:0]       timer_q, timer_d;
  logic                   busy_q, busy_d;
  logic                   pulse_q, pulse_d;

  logic                   bus_idle;
  logic [NUM_MASTERS-1:0] act;
  logic [IDX_W:0]         pick_rr;
  logic [IDX_W:0]         pick_to;
  state_t                 ra_state;
  logic [IDX_W-1:0]       ra_target;

  // First active index scanning upward from base+1; base itself is checked last.
  // MSB of the result flags that some index was found.
  function automatic logic [IDX_W:0] rr_pick(input logic [NUM_MASTERS-1:0] vec,
                                             input logic [IDX_W-1:0]       base);
    logic [IDX_W:0] res;
    int             idx;
    res = '0;
    for (int i = int'(NUM_MASTERS); i >= 1; i--) begin
      idx = (int'(base) + i) % int'(NUM_MASTERS);
      if (vec[IDX_W'(idx)]) res = {1'b1, IDX_W'(idx)};
    end
    return res;
  endfunction

  assign bus_idle = bus.frame_n & bus.irdy_n;
  assign act      = ~bus.req_n;
  assign pick_rr  = rr_pick(act, ptr_q);
  assign pick_to  = rr_pick(act & ~(NUM_MASTERS'(1) << owner_q), owner_q);

  // Common re-arbitration outcome used when the bus becomes free.
  always_comb begin
    ra_state  = SWITCH;
    ra_target = target_q;
    if (!pick_rr[IDX_W]) begin
      if (owner_q == PARK_IDX) ra_state = PARK;
      else                     ra_target = PARK_IDX;
    end else if (pick_rr[IDX_W-1:0] == owner_q) begin
      ra_state = GRANTED;
    end else begin
      ra_target = pick_rr[IDX_W-1:0];
    end
  end

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    owner_d  = owner_q;
    ptr_d    = ptr_q;
    target_d = target_q;
    timer_d  = '0;
    pulse_d  = 1'b0;
    unique case (state_q)
      SWITCH: begin
        gnt_d   = ~(NUM_MASTERS'(1) << target_q);
        owner_d = target_q;
        state_d = act[target_q] ? GRANTED : PARK;
      end
      PARK: begin
        if (!bus_idle) begin
          state_d = BUSY;
          ptr_d   = owner_q;
        end else begin
          state_d  = ra_state;
          target_d = ra_target;
        end
      end
      GRANTED: begin
        if (!bus.frame_n) begin
          state_d = BUSY;
          ptr_d   = owner_q;
        end else if (!act[owner_q]) begin
          state_d  = ra_state;
          target_d = ra_target;
        end else if (bus_idle && timer_q == TMR_LAST) begin
          pulse_d  = 1'b1;
          ptr_d    = owner_q;
          target_d = pick_to[IDX_W] ? pick_to[IDX_W-1:0] : PARK_IDX;
          state_d  = SWITCH;
        end else if (bus_idle) begin
          timer_d = (timer_q == TMR_MAX) ? timer_q : timer_q + TMR_W'(1);
        end else begin
          timer_d = timer_q;
        end
      end
      BUSY: begin
        if (bus_idle) begin
          state_d  = ra_state;
          target_d = ra_target;
        end
      end
      default: state_d = SWITCH;
    endcase
    // Any path into SWITCH drops every grant for one cycle.
    if (state_d == SWITCH && state_q != SWITCH) gnt_d = '1;
    busy_d = (state_d == BUSY);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= SWITCH;
      gnt_q    <= '1;
      owner_q  <= PARK_IDX;
      ptr_q    <= PARK_IDX;
      target_q <= PARK_IDX;
      timer_q  <= '0;
      busy_q   <= 1'b0;
      pulse_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      owner_q  <= owner_d;
      ptr_q    <= ptr_d;
      target_q <= target_d;
      timer_q  <= timer_d;
      busy_q   <= busy_d;
      pulse_q  <= pulse_d;
    end
  end

  assign bus.gnt_n         = gnt_q;
  assign bus.owner         = owner_q;
  assign bus.bus_busy      = busy_q;
  assign bus.timeout_pulse = pulse_q;
endmodule

// File: tb/tb_pci_bus_arbiter.sv
// Directed self-checking bench for pci_bus_arbiter (4 masters, timeout 16, park on 0).
module tb_pci_bus_arbiter;
  logic clk = 1'b0;
  logic reset;
  int   n_chk  = 0;
  int   n_pass = 0;
  int   n_fail = 0;
  bit   run    = 1'b0;

  pci_bus_arbiter_if #(.NUM_MASTERS(4)) bus ();

  pci_bus_arbiter #(.NUM_MASTERS(4), .GNT_TIMEOUT(16), .PARK_MASTER(0)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset       = 1'b1;
    bus.req_n   = 4'hF;
    bus.frame_n = 1'b1;
    bus.irdy_n  = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // At most one grant may be active at any time.
  always @(negedge clk) begin
    if (run) begin
      n_chk++;
      assert ($countones(~bus.gnt_n) <= 1) n_pass++;
      else begin
        n_fail++;
        $error("FAIL onehot: observed gnt_n=%b expected at most one low bit", bus.gnt_n);
      end
    end
  end

  initial begin
    int         order [5];
    logic [3:0] g;
    order = '{1, 2, 3, 0, 1};

    do_reset();
    run = 1'b1;
    chk("rst_gnt",   32'(bus.gnt_n), 32'hF);
    chk("rst_owner", 32'(bus.owner), 32'h0);
    chk("rst_busy",  32'(bus.bus_busy), 32'h0);
    chk("rst_pulse", 32'(bus.timeout_pulse), 32'h0);
    tick();
    chk("park_gnt",   32'(bus.gnt_n), 32'hE);
    chk("park_owner", 32'(bus.owner), 32'h0);
    chk("park_busy",  32'(bus.bus_busy), 32'h0);

    // Master 2 requests from the parked state.
    bus.req_n = 4'b1011;
    tick();
    chk("m2_switch_gnt", 32'(bus.gnt_n), 32'hF);
    tick();
    chk("m2_gnt",   32'(bus.gnt_n), 32'hB);
    chk("m2_owner", 32'(bus.owner), 32'h2);
    bus.frame_n = 1'b0; bus.irdy_n = 1'b0;
    tick();
    chk("m2_busy",     32'(bus.bus_busy), 32'h1);
    chk("m2_busy_gnt", 32'(bus.gnt_n), 32'hB);
    bus.frame_n = 1'b1;
    tick();
    chk("m2_lastdata_busy", 32'(bus.bus_busy), 32'h1);
    bus.irdy_n = 1'b1; bus.req_n = 4'hF;
    tick();
    chk("m2_done_busy", 32'(bus.bus_busy), 32'h0);
    chk("m2_done_gnt",  32'(bus.gnt_n), 32'hF);
    tick();
    chk("m2_repark_gnt", 32'(bus.gnt_n), 32'hE);

    // Round robin with everybody requesting, starting from ptr=0.
    do_reset();
    tick();
    bus.req_n = 4'b0000;
    tick();
    chk("rr_gap0", 32'(bus.gnt_n), 32'hF);
    for (int k = 0; k < 5; k++) begin
      tick();
      g = ~(4'b0001 << order[k]);
      chk("rr_gnt",   32'(bus.gnt_n), 32'(g));
      chk("rr_owner", 32'(bus.owner), 32'(order[k]));
      bus.frame_n = 1'b0; bus.irdy_n = 1'b0;
      tick();
      chk("rr_busy", 32'(bus.bus_busy), 32'h1);
      bus.frame_n = 1'b1;
      tick();
      bus.irdy_n = 1'b1;
      tick();
      chk("rr_gap", 32'(bus.gnt_n), 32'hF);
    end

    // Grant timeout on master 3 while master 1 waits.
    do_reset();
    tick();
    bus.req_n = 4'b0111;
    tick();
    chk("to_switch_gnt", 32'(bus.gnt_n), 32'hF);
    tick();
    chk("to_gnt", 32'(bus.gnt_n), 32'h7);
    bus.req_n = 4'b0101;
    repeat (15) begin
      tick();
      chk("to_hold_gnt",   32'(bus.gnt_n), 32'h7);
      chk("to_hold_pulse", 32'(bus.timeout_pulse), 32'h0);
    end
    tick();
    chk("to_pulse",   32'(bus.timeout_pulse), 32'h1);
    chk("to_revoked", 32'(bus.gnt_n), 32'hF);
    tick();
    chk("to_next_gnt",   32'(bus.gnt_n), 32'hD);
    chk("to_next_owner", 32'(bus.owner), 32'h1);
    chk("to_pulse_clr",  32'(bus.timeout_pulse), 32'h0);

    // Frame falls on the edge the timeout would fire: transaction wins.
    repeat (15) tick();
    bus.frame_n = 1'b0;
    tick();
    chk("nto_pulse", 32'(bus.timeout_pulse), 32'h0);
    chk("nto_busy",  32'(bus.bus_busy), 32'h1);
    chk("nto_gnt",   32'(bus.gnt_n), 32'hD);

    // Sole requester keeps the grant across back-to-back transactions.
    do_reset();
    tick();
    bus.req_n = 4'b1101;
    tick();
    tick();
    chk("solo_gnt", 32'(bus.gnt_n), 32'hD);
    bus.frame_n = 1'b0;
    tick();
    chk("solo_busy1", 32'(bus.bus_busy), 32'h1);
    bus.frame_n = 1'b1;
    tick();
    chk("solo_idle_gnt",  32'(bus.gnt_n), 32'hD);
    chk("solo_idle_busy", 32'(bus.bus_busy), 32'h0);
    bus.frame_n = 1'b0;
    tick();
    chk("solo_busy2", 32'(bus.bus_busy), 32'h1);
    chk("solo_gnt2",  32'(bus.gnt_n), 32'hD);

    // Reset in the middle of a transaction.
    reset = 1'b1;
    tick();
    chk("mr_gnt",   32'(bus.gnt_n), 32'hF);
    chk("mr_busy",  32'(bus.bus_busy), 32'h0);
    chk("mr_owner", 32'(bus.owner), 32'h0);
    reset = 1'b0; bus.frame_n = 1'b1; bus.req_n = 4'hF;
    tick();
    chk("mr_park_gnt", 32'(bus.gnt_n), 32'hE);

    // Parked master requesting keeps its grant with no gap.
    bus.req_n = 4'b1110;
    tick();
    chk("pk_zero_gap", 32'(bus.gnt_n), 32'hE);
    bus.frame_n = 1'b0;
    tick();
    chk("pk_busy",     32'(bus.bus_busy), 32'h1);
    chk("pk_busy_gnt", 32'(bus.gnt_n), 32'hE);
    bus.frame_n = 1'b1;
    tick();

    run = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
